// File: rtl/bin_gray_conv_pipe.sv
// Binary/Gray code converter with a one-deep registered output stage and
// valid/ready handshakes on both sides. A free-running counter tracks
// completed output transfers.
// Optional feature: define BIN_GRAY_CONV_PARITY_EN to add the out_par port,
// a registered XOR-reduction of the result word.
module bin_gray_conv_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
`ifdef BIN_GRAY_CONV_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_fire, out_fire;

  // Gray code of a binary word: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary value of a Gray word: running XOR from the MSB downwards.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The output register can take a new word when it is empty or being drained.
  assign in_ready  = !valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = valid_q && out_ready;

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_mode  = mode_q;
  assign xfer_cnt  = cnt_q;

  // Select the conversion for the incoming word; the increment wraps naturally.
  always_comb begin
    data_d = in_data;
    case (in_mode)
      2'b00:   data_d = bin2gray(in_data);
      2'b01:   data_d = gray2bin(in_data);
      2'b10:   data_d = bin2gray(gray2bin(in_data) + WIDTH'(1));
      default: data_d = in_data;
    endcase
  end

  // Output stage: load on input transfer, empty on a drain without refill, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= 2'b00;
    end else if (in_fire) begin
      valid_q <= 1'b1;
      data_q  <= data_d;
      mode_q  <= in_mode;
    end else if (out_fire) begin
      valid_q <= 1'b0;
    end
  end

  // Completed output transfers, wrapping silently at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_fire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef BIN_GRAY_CONV_PARITY_EN
  logic par_q;

  assign out_par = par_q;

  // Parity of the result, captured together with the result word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (in_fire) begin
      par_q <= ^data_d;
    end
  end
`endif

endmodule

// File: tb/tb_bin_gray_conv_pipe.sv
// Self-checking bench for bin_gray_conv_pipe (WIDTH=8). Two instances share
// the stimulus: one with the default 16-bit counter, one with a 4-bit counter
// to exercise counter wrap. A reference model predicts every output.
module tb_bin_gray_conv_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_ready;

  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_mode;
  logic [15:0] xfer_cnt;

  logic        in_ready4, out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  out_mode4;
  logic [3:0]  xfer_cnt4;

`ifdef BIN_GRAY_CONV_PARITY_EN
  logic out_par, out_par4;
`endif

  int passCount  = 0;
  int checkCount = 0;

  bin_gray_conv_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
`ifdef BIN_GRAY_CONV_PARITY_EN
    .out_par(out_par),
`endif
    .xfer_cnt(xfer_cnt)
  );

  bin_gray_conv_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_mode(out_mode4),
`ifdef BIN_GRAY_CONV_PARITY_EN
    .out_par(out_par4),
`endif
    .xfer_cnt(xfer_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference conversions written from the code definitions.
  function automatic logic [7:0] refB2G(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] refG2B(input logic [7:0] g);
    logic [7:0] b;
    b = 8'h00;
    for (int s = 0; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [7:0] refConv(input logic [7:0] d, input logic [1:0] m);
    int unsigned v;
    case (m)
      2'b00: return refB2G(d);
      2'b01: return refG2B(d);
      2'b10: begin
        v = (int'(refG2B(d)) + 1) % 256;
        return refB2G(8'(v));
      end
      default: return d;
    endcase
  endfunction

  // Model state: what the output register and counter must hold.
  bit         mValid;
  logic [7:0] mData;
  logic [1:0] mMode;
  int         mCount;

  // Model updates once per rising edge from the inputs the DUT saw.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mValid = 1'b0;
      mData  = 8'h00;
      mMode  = 2'b00;
      mCount = 0;
    end else begin
      if (mValid && out_ready) mCount = mCount + 1;
      if (in_valid && (!mValid || out_ready)) begin
        mValid = 1'b1;
        mData  = refConv(in_data, in_mode);
        mMode  = in_mode;
      end else if (mValid && out_ready) begin
        mValid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cmp_in_ready", 32'(in_ready), 32'(!mValid || out_ready));
      checkOutput("cmp_in_ready4", 32'(in_ready4), 32'(!mValid || out_ready));
      checkOutput("cmp_out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("cmp_cnt", 32'(xfer_cnt), 32'(mCount % 65536));
      checkOutput("cmp_cnt4", 32'(xfer_cnt4), 32'(mCount % 16));
      if (mValid) begin
        checkOutput("cmp_out_data", 32'(out_data), 32'(mData));
        checkOutput("cmp_out_mode", 32'(out_mode), 32'(mMode));
        checkOutput("cmp_out_data4", 32'(out_data4), 32'(mData));
`ifdef BIN_GRAY_CONV_PARITY_EN
        checkOutput("cmp_out_par", 32'(out_par), 32'(^mData));
        checkOutput("cmp_out_par4", 32'(out_par4), 32'(^mData));
`endif
      end
    end
  end

  // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] m, input logic r);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  logic [7:0] prevData;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_mode = 2'b00;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_cnt", 32'(xfer_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Directed conversions with hand-computed results.
    applyStimulus(1'b1, 8'hB5, 2'b00, 1'b1);
    checkOutput("b2g_valid", 32'(out_valid), 32'd1);
    checkOutput("b2g_B5", 32'(out_data), 32'hEF);
    checkOutput("b2g_mode", 32'(out_mode), 32'd0);
`ifdef BIN_GRAY_CONV_PARITY_EN
    checkOutput("b2g_par", 32'(out_par), 32'd1);
`endif
    applyStimulus(1'b1, 8'hEF, 2'b01, 1'b1);
    checkOutput("g2b_EF", 32'(out_data), 32'hB5);
    checkOutput("g2b_mode", 32'(out_mode), 32'd1);
    applyStimulus(1'b1, 8'h80, 2'b10, 1'b1);
    checkOutput("ginc_wrap", 32'(out_data), 32'h00);
    applyStimulus(1'b1, 8'h00, 2'b10, 1'b1);
    checkOutput("ginc_00", 32'(out_data), 32'h01);
    applyStimulus(1'b1, 8'h3C, 2'b11, 1'b1);
    checkOutput("pass_3C", 32'(out_data), 32'h3C);
    checkOutput("pass_mode", 32'(out_mode), 32'd3);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_cnt", 32'(xfer_cnt), 32'd5);

    // Full-rate stream: consecutive Gray codes differ in one bit.
    pulseReset();
    prevData = 8'h00;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8'(i), 2'b00, 1'b1);
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      if (i > 0) checkOutput("stream_1bit", 32'($countones(out_data ^ prevData)), 32'd1);
      prevData = out_data;
    end
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);
    checkOutput("stream_cnt", 32'(xfer_cnt), 32'd256);
    checkOutput("stream_cnt4", 32'(xfer_cnt4), 32'd0);

    // Backpressure: pending word held, new word waits, both delivered once.
    applyStimulus(1'b1, 8'h12, 2'b11, 1'b1);
    checkOutput("bp_first", 32'(out_data), 32'h12);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'h34, 2'b11, 1'b0);
      checkOutput("bp_hold_data", 32'(out_data), 32'h12);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    applyStimulus(1'b1, 8'h34, 2'b11, 1'b1);
    checkOutput("bp_second", 32'(out_data), 32'h34);
    checkOutput("bp_cnt_mid", 32'(xfer_cnt), 32'd257);
    applyStimulus(1'b0, 8'h00, 2'b11, 1'b1);
    checkOutput("bp_cnt_end", 32'(xfer_cnt), 32'd258);
    checkOutput("bp_empty", 32'(out_valid), 32'd0);

    // Narrow counter wraps after 16 transfers.
    pulseReset();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i), 2'b11, 1'b1);
    checkOutput("cnt4_wrap16", 32'(xfer_cnt4), 32'd0);
    applyStimulus(1'b0, 8'h00, 2'b11, 1'b1);
    checkOutput("cnt4_after17", 32'(xfer_cnt4), 32'd1);
    checkOutput("cnt16_after17", 32'(xfer_cnt), 32'd17);

    // Asynchronous reset mid-cycle while a word is stalled.
    applyStimulus(1'b1, 8'h55, 2'b00, 1'b1);
    applyStimulus(1'b1, 8'h66, 2'b00, 1'b0);
    checkOutput("async_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    checkOutput("async_data", 32'(out_data), 32'd0);
    checkOutput("async_cnt", 32'(xfer_cnt), 32'd0);
    checkOutput("async_cnt4", 32'(xfer_cnt4), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 8'hA3, 2'b00, 1'b1);
    checkOutput("post_rst_A3", 32'(out_data), 32'hF2);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b1);
    checkOutput("post_rst_cnt", 32'(xfer_cnt), 32'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
